// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between instruction fetch (i_*)
//   and the data port (d_*). Each access takes MEM_LAT cycles with the memory
//   inputs held stable, then a one-cycle response (RESP) pulses rvalid.
//   The data port wins collisions. When the MEM_ARB_STARVE_EN macro is
//   defined, the instruction port is forced to win after STARVE_MAX
//   consecutive data grants while i_req is pending. Without the macro, the
//   data port has strict priority and STARVE_MAX has no effect.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   i_req/i_addr        instruction read request (held until i_gnt)
//   i_gnt/i_rvalid      grant pulse / read data valid pulse
//   i_rdata             last fetched instruction word
//   d_req/d_we/d_addr/d_wdata  data request (held until d_gnt)
//   d_gnt/d_rvalid      grant pulse / load data valid or store ack pulse
//   d_rdata             last loaded data word (unchanged by store acks)
//   m_cs/m_we/m_addr/m_wdata/m_rdata  memory interface
//   stall_if/stall_mem  pipeline hold requests
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_cs,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int ACC_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q;
  logic [ACC_W-1:0]    acc_cnt_q;
  logic                port_q;     // 1 = data port owns the current access
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                idle;
  logic                pick_d;
  logic                acc_last;

  // Grants are only issued out of IDLE and never while reset is held, so a
  // requester cannot consume a grant for an access that reset discards.
  assign idle = (state_q == IDLE) & ~reset;

`ifdef MEM_ARB_STARVE_EN
  localparam int STV_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
  logic [STV_W-1:0] starve_q;
  logic             starved;
  assign starved = (starve_q == STV_W'(STARVE_MAX));
  assign pick_d  = d_req & ~(i_req & starved);
`else
  // Strict data priority; the comparison is constant-false and only keeps
  // STARVE_MAX referenced in this build.
  assign pick_d  = d_req | (STARVE_MAX < 0);
`endif

  assign d_gnt    = idle & pick_d;
  assign i_gnt    = idle & i_req & ~pick_d;
  assign acc_last = (acc_cnt_q == ACC_W'(MEM_LAT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_STARVE_EN
      starve_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_gnt | d_gnt) begin
            state_q   <= ACCESS;
            acc_cnt_q <= '0;
          end
        end
        ACCESS: begin
          if (acc_last) begin
            state_q <= RESP;
            // Read data is only guaranteed on the last cycle of the window.
            if (!we_q) begin
              if (port_q) d_rdata_q <= m_rdata;
              else        i_rdata_q <= m_rdata;
            end
          end else begin
            acc_cnt_q <= acc_cnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
`ifdef MEM_ARB_STARVE_EN
      if (i_gnt || (idle && !i_req)) begin
        starve_q <= '0;
      end else if (d_gnt && i_req && !starved) begin
        starve_q <= starve_q + 1'b1;
      end
`endif
    end
  end

  // Access descriptor captured at grant; only meaningful in ACCESS/RESP.
  always_ff @(posedge clk) begin
    if (i_gnt || d_gnt) begin
      port_q  <= d_gnt;
      we_q    <= d_gnt & d_we;
      addr_q  <= d_gnt ? d_addr : i_addr;
      wdata_q <= d_wdata;
    end
  end

  assign m_cs      = (state_q == ACCESS);
  assign m_we      = m_cs & we_q;
  assign m_addr    = m_cs ? addr_q  : '0;
  assign m_wdata   = m_cs ? wdata_q : '0;

  assign i_rvalid  = (state_q == RESP) & ~port_q;
  assign d_rvalid  = (state_q == RESP) &  port_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  assign stall_if  = i_req & ~i_rvalid;
  assign stall_mem = d_req & ~d_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  typedef struct {
    logic        port;   // 1 = data port
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_cs, m_we, stall_if, stall_mem;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

  // Second instance, MEM_LAT = 1, used for the back-to-back fetch sweep.
  logic        i_req2, d_req2, d_we2;
  logic [31:0] i_addr2, d_addr2, d_wdata2;
  logic        i_gnt2, i_rvalid2, d_gnt2, d_rvalid2, m_cs2, m_we2, stall_if2, stall_mem2;
  logic [31:0] i_rdata2, d_rdata2, m_addr2, m_wdata2, m_rdata2;

  int   total = 0;
  int   bad   = 0;
  rsp_t rq[$];
  logic gq[$];
  logic [31:0] q2[$];
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)) dut2 (
    .clk(clk), .reset(reset),
    .i_req(i_req2), .i_addr(i_addr2), .i_gnt(i_gnt2), .i_rvalid(i_rvalid2), .i_rdata(i_rdata2),
    .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
    .m_cs(m_cs2), .m_we(m_we2), .m_addr(m_addr2), .m_wdata(m_wdata2), .m_rdata(m_rdata2),
    .stall_if(stall_if2), .stall_mem(stall_mem2)
  );

  // Memory models
  assign m_rdata  = mem[m_addr[9:2]];
  assign m_rdata2 = 32'hA500_0000 | {24'h0, m_addr2[7:0]};

  always @(posedge clk) begin
    if (m_cs && m_we) mem[m_addr[9:2]] <= m_wdata;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor for the MEM_LAT=2 instance
  int          cyc = 0;
  int          gnt_cyc = 0;
  int          cs_run = 0;
  logic [31:0] cs_addr = '0;
  logic [31:0] exp_drd = '0;

  always @(negedge clk) begin
    rsp_t e;
    logic eg;
    cyc++;
    if (reset) begin
      cs_run  = 0;
      exp_drd = '0;
    end else begin
      if (i_gnt || d_gnt) begin
        chk("gnt_busy", {m_cs, i_rvalid, d_rvalid}, 0);
        chk("gnt_both", i_gnt & d_gnt, 0);
        if (gq.size() == 0) chk("gnt_unexpected", 1, 0);
        else begin
          eg = gq.pop_front();
          chk("gnt_port", d_gnt, eg);
        end
        gnt_cyc = cyc;
        cs_run  = 0;
      end
      if (m_cs) begin
        if (cs_run == 0) cs_addr = m_addr;
        else chk("m_addr_hold", m_addr, cs_addr);
        cs_run++;
      end
      if (i_rvalid || d_rvalid) begin
        chk("rvalid_both", i_rvalid & d_rvalid, 0);
        if (rq.size() == 0) chk("rvalid_unexpected", 1, 0);
        else begin
          e = rq.pop_front();
          chk("rsp_port", d_rvalid, e.port);
          chk("rsp_latency", cyc - gnt_cyc, 3);
          chk("cs_cycles", cs_run, 2);
          chk("m_addr", cs_addr, e.addr);
          if (!e.port) begin
            chk("i_rdata", i_rdata, e.data);
            chk("stall_if_rv", stall_if, 0);
          end else if (!e.we) begin
            chk("d_rdata", d_rdata, e.data);
            exp_drd = e.data;
          end else begin
            chk("d_rdata_wack", d_rdata, exp_drd);
          end
        end
      end
    end
  end

  // Monitor for the MEM_LAT=1 instance
  int g2_cyc = 0;
  int prev_rv = -1;

  always @(negedge clk) begin
    if (!reset) begin
      if (i_gnt2 || d_gnt2) begin
        chk("gnt2_busy", {m_cs2, i_rvalid2, d_gnt2}, 0);
        g2_cyc = cyc;
      end
      if (i_rvalid2 || d_rvalid2) begin
        chk("rv2_port", d_rvalid2, 0);
        if (q2.size() == 0) chk("rv2_unexpected", 1, 0);
        else chk("i_rdata2", i_rdata2, q2.pop_front());
        chk("rv2_latency", cyc - g2_cyc, 2);
        if (prev_rv >= 0) chk("rv2_gap", cyc - prev_rv, 3);
        prev_rv = cyc;
      end
    end
  end

  // Returns just after the clock edge that follows the requested grant.
  task automatic wait_gnt(input logic port);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? d_gnt : i_gnt) && n < 60);
    chk("gnt_timeout", (port ? d_gnt : i_gnt), 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || q2.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n >= 100, 0);
    @(posedge clk); #1;
  endtask

  task automatic i_access(input logic [31:0] a, input logic [31:0] exp);
    rsp_t e;
    e = '{port: 1'b0, we: 1'b0, addr: a, data: exp};
    gq.push_back(1'b0);
    rq.push_back(e);
    i_req = 1'b1; i_addr = a;
    #1 chk("stall_if_pend", stall_if, 1);
    wait_gnt(1'b0);
    i_req = 1'b0;
    drain();
  endtask

  task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp);
    rsp_t e;
    e = '{port: 1'b1, we: we, addr: a, data: exp};
    gq.push_back(1'b1);
    rq.push_back(e);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    #1 chk("stall_mem_pend", stall_mem, 1);
    wait_gnt(1'b1);
    d_req = 1'b0;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t e;
    logic eg, last, fin;
    int   ng, n;

    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[16] = 32'h0000_0015;  // byte address 0x40
    reset = 1'b1;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    i_req2 = 0; d_req2 = 0; d_we2 = 0; i_addr2 = 0; d_addr2 = 0; d_wdata2 = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_gnt",    {i_gnt, d_gnt}, 0);
    chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    chk("rst_mcs",    {m_cs, m_we}, 0);
    chk("rst_maddr",  m_addr, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_stall",  {stall_if, stall_mem}, 0);
    @(posedge clk); #1;

    // Single fetch
    i_access(32'h40, 32'h15);

    // Store then load, write acks leave d_rdata alone
    d_access(1'b1, 32'h100, 32'hDEADBEEF, 32'h0);
    d_access(1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
    d_access(1'b1, 32'h104, 32'h12345678, 32'h0);
    d_access(1'b0, 32'h104, 32'h0, 32'h12345678);

    // Collision: both requests held through eight grants
    for (int k = 0; k < 8; k++) begin
`ifdef MEM_ARB_STARVE_EN
      eg = (k % 4 == 3) ? 1'b0 : 1'b1;
`else
      eg = 1'b1;
`endif
      e = '{port: eg, we: 1'b0, addr: eg ? 32'h100 : 32'h40, data: eg ? 32'hDEADBEEF : 32'h15};
      gq.push_back(eg);
      rq.push_back(e);
      last = eg;
    end
    fin = ~last;
    e = '{port: fin, we: 1'b0, addr: fin ? 32'h100 : 32'h40, data: fin ? 32'hDEADBEEF : 32'h15};
    gq.push_back(fin);
    rq.push_back(e);
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    #1;
    chk("coll_stall_if",  stall_if, 1);
    chk("coll_stall_mem", stall_mem, 1);
    ng = 0; n = 0;
    while (ng < 8 && n < 400) begin
      @(negedge clk);
      n++;
      if (i_gnt || d_gnt) ng++;
    end
    chk("coll_grants", ng, 8);
    @(posedge clk); #1;
    if (fin) i_req = 1'b0; else d_req = 1'b0;
    wait_gnt(fin);
    i_req = 1'b0; d_req = 1'b0;
    drain();

    // Reset during the second ACCESS cycle of a load
    gq.push_back(1'b1);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    wait_gnt(1'b1);           // now in ACCESS cycle 1
    d_req = 1'b0;
    @(negedge clk);
    chk("acc1_cs", m_cs, 1);
    @(posedge clk); #1;        // ACCESS cycle 2
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_cs", m_cs, 0);
    chk("rstmid_rv", d_rvalid, 0);
    chk("rstmid_d_rdata", d_rdata, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstmid_no_rv", {d_rvalid, i_rvalid, m_cs}, 0);
    end
    @(posedge clk); #1;
    d_access(1'b0, 32'h40, 32'h0, 32'h15);
    d_access(1'b1, 32'h44, 32'h55AA55AA, 32'h0);
    d_access(1'b0, 32'h44, 32'h0, 32'h55AA55AA);

    // MEM_LAT=1 back-to-back fetch sweep
    for (int k = 0; k < 10; k++) q2.push_back(32'hA500_0000 | 32'(k * 4));
    i_req2 = 1'b1; i_addr2 = 32'h0;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!i_gnt2 && n < 20);
      chk("sweep_gnt_timeout", i_gnt2, 1);
      @(posedge clk); #1;
      if (k < 9) i_addr2 = 32'((k + 1) * 4);
      else i_req2 = 1'b0;
    end
    drain();

    chk("gq_left", gq.size(), 0);
    chk("rq_left", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
